// File: rtl/sub_iter_if.sv
// Operand/result handshake bundle for the iterative subtractor.
// The slave side is the subtractor; the master side is the ALU operand/writeback pair.
interface sub_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             borrow;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, d, borrow, overflow, zero
  );

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, d, borrow, overflow, zero
  );
endinterface

// File: rtl/sub_iter.sv
// Multi-cycle subtractor d = a - b, CHUNK bits per clock through a ripple-borrow chain.
// The borrow between chunks is held in brw_q; flags are registered on the final chunk.
module sub_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  sub_iter_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             sgn_q, sgn_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [WIDTH-1:0] a_sh, b_sh, d_ins;
  logic [CHUNK-1:0] ca, cb, cd;
  logic             bin;
  logic             last;

  assign last = (idx_q == IDXW'(NCHUNK - 1));

  // Chunk selected by shifting rather than an indexed part-select.
  always_comb begin
    a_sh = a_q >> (32'(idx_q) * 32'(CHUNK));
    b_sh = b_q >> (32'(idx_q) * 32'(CHUNK));
    ca   = a_sh[CHUNK-1:0];
    cb   = b_sh[CHUNK-1:0];
    cd   = '0;
    bin  = brw_q;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      cd[i] = ca[i] ^ cb[i] ^ bin;
      bin   = (~ca[i] & cb[i]) | (~(ca[i] ^ cb[i]) & bin);
    end
    d_ins = (d_q & ~(WIDTH'({CHUNK{1'b1}}) << (32'(idx_q) * 32'(CHUNK))))
          | (WIDTH'(cd) << (32'(idx_q) * 32'(CHUNK)));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    sgn_d    = sgn_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sgn_d   = bus.is_signed;
          brw_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d   = d_ins;
        brw_d = bin;
        idx_d = idx_q + IDXW'(1);
        if (last) begin
          idx_d    = '0;
          borrow_d = bin;
          zero_d   = (d_ins == '0);
          ovf_d    = sgn_q & (a_q[WIDTH-1] != b_q[WIDTH-1]) & (d_ins[WIDTH-1] != a_q[WIDTH-1]);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      sgn_q    <= 1'b0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      sgn_q    <= sgn_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.d         = d_q;
  assign bus.borrow    = borrow_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_sub_iter.sv
// Self-checking bench for sub_iter: directed vector table, corner-case sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_sub_iter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  sub_iter_if #(.WIDTH(32)) bus ();

  sub_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] d;
    logic        brw;
    logic        ovf;
    logic        zr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus a 64-bit signed range test.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output logic [31:0] d, output logic brw, output logic ovf, output logic zr);
    longint sa, sb, diff;
    sa   = longint'({{32{a[31]}}, a});
    sb   = longint'({{32{b[31]}}, b});
    diff = sa - sb;
    d    = a - b;
    brw  = (a < b);
    ovf  = sgn && ((diff > 64'sd2147483647) || (diff < -64'sd2147483648));
    zr   = (d == 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] rd, output logic rb, output logic ro, output logic rz);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = sgn;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.out_valid && n < 20);
    chk("latency", 32'(n), 32'd4);
    rd = bus.d;
    rb = bus.borrow;
    ro = bus.overflow;
    rz = bus.zero;
    if (bus.out_ready) begin
      @(posedge clk); #1;
      chk("out_valid_one_cycle", 32'(bus.out_valid), 32'd0);
      chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
      chk("d_held_after_hs", bus.d, rd);
    end
  endtask

  vec_t        vecs[9];
  logic [31:0] rd, ed, hold_d;
  logic        rb, ro, rz, eb, eo, ez;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{32'd10,        32'd3,          1'b0, 32'd7,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0100, 32'd1,          1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'd3,         32'd10,         1'b0, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'd1,          1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678,  1'b0, 32'd0,        1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'd0,         32'h7FFF_FFFF,  1'b1, 32'h8000_0001, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF, 32'd0,          1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_d", bus.d, 32'd0);
    chk("rst_flags", {29'd0, bus.borrow, bus.overflow, bus.zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, rd, rb, ro, rz);
      chk($sformatf("vec%0d_d", i), rd, vecs[i].d);
      chk($sformatf("vec%0d_borrow", i), 32'(rb), 32'(vecs[i].brw));
      chk($sformatf("vec%0d_overflow", i), 32'(ro), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_zero", i), 32'(rz), 32'(vecs[i].zr));
    end

    // Backpressure: result must hold while inputs churn.
    bus.out_ready = 1'b0;
    run_op(32'h0000_0100, 32'd1, 1'b0, rd, rb, ro, rz);
    chk("bp_d", rd, 32'h0000_00FF);
    hold_d = rd;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk); #1;
      chk("bp_d_stable", bus.d, hold_d);
      chk("bp_flags_stable", {29'd0, bus.borrow, bus.overflow, bus.zero}, {29'd0, rb, ro, rz});
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(32'd7, 32'd9, 1'b1, rd, rb, ro, rz);
    model(32'd7, 32'd9, 1'b1, ed, eb, eo, ez);
    chk("post_bp_d", rd, ed);
    chk("post_bp_borrow", 32'(rb), 32'(eb));

    // Asynchronous reset after two chunks have been processed.
    bus.in_valid = 1'b1;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0000_1234;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_d", bus.d, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd5, 32'd5, 1'b0, rd, rb, ro, rz);
    chk("after_rst_d", rd, 32'd0);
    chk("after_rst_zero", 32'(rz), 32'd1);
    chk("after_rst_borrow", 32'(rb), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rbv;
      logic        rs;
      ra  = (i % 5 == 0) ? {1'b1, 31'($urandom_range(0, 3))} : $urandom;
      rbv = (i % 7 == 0) ? ra : $urandom;
      rs  = 1'($urandom);
      run_op(ra, rbv, rs, rd, rb, ro, rz);
      model(ra, rbv, rs, ed, eb, eo, ez);
      chk("rand_d", rd, ed);
      chk("rand_flags", {29'd0, rb, ro, rz}, {29'd0, eb, eo, ez});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_iter.md
Name: sub_iter

Overview:
- Multi-cycle integer subtractor computing d = a - b. It is the inverse companion of the integer adders in the integer ALU.
- Processes CHUNK bits per clock through a ripple-borrow chain of full-subtractor cells. The borrow is carried between cycles in a register.
- Uses a valid/ready handshake on both the input and output sides. It sits between the ALU operand stage and the result writeback stage.
- Flags: unsigned borrow, signed overflow (when is_signed is set) and zero.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits processed per cycle. Must divide WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- is_signed  input  1  1 = two's-complement operands; enables the overflow flag.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- d  output  WIDTH  difference, a - b mod 2^WIDTH.
- borrow  output  1  final borrow out; 1 if and only if a < b unsigned.
- overflow  output  1  signed overflow. Always 0 when is_signed = 0.
- zero  output  1  d == 0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (asserted at any time, including mid-operation):
  - State goes to IDLE; any in-flight operation is discarded.
  - in_ready=1, out_valid=0.
  - d=0, borrow=0, overflow=0, zero=0.
  - Internal chunk index and borrow register = 0.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from registered state.
- IDLE:
  - On a rising edge with in_valid && in_ready: latch a, b, is_signed. Clear the borrow register and the index. Go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - Each cycle processes chunk idx, bits [idx*CHUNK +: CHUNK]. Per bit: diff = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
  - Chunk borrow-in = borrow register; chunk borrow-out is written back to it.
  - Difference bits are written into the d register at the chunk position.
  - After chunk NCHUNK-1, go to DONE.
- Timing: out_valid rises exactly NCHUNK cycles after the accepting edge (4 cycles at the defaults).
- DONE:
  - borrow = final borrow register.
  - overflow = is_signed & (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]).
  - zero = (d == 0).
  - All flags are registered and valid in the same cycle as out_valid.
  - Hold d and flags stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE next cycle, so in_ready=1 one cycle after the handshake. No back-to-back accept in the same cycle.
- Busy rule: in_valid, a, b and is_signed are ignored outside IDLE. Operands are latched, so input changes during RUN do not affect the result.
- d and flags keep their last values after the output handshake until overwritten by the next operation. Only out_valid qualifies them.
- Boundaries:
  - Borrow must propagate across chunk boundaries, e.g. 0x100 - 1.
  - Wrap-around is modulo 2^WIDTH.
  - is_signed changes only the overflow flag; d and borrow are identical in both modes.
- Throughput: one operation per NCHUNK+2 cycles minimum.

Test Plan (WIDTH=32, CHUNK=8):
1. a=10, b=3, is_signed=0, out_ready=1.
   - Expect d=7, borrow=0, overflow=0, zero=0.
   - out_valid rises 4 cycles after accept and lasts 1 cycle; in_ready=1 the following cycle.
2. a=0x00000100, b=1.
   - Expect d=0x000000FF, borrow=0 (cross-chunk borrow).
   - Then a=3, b=10: expect d=0xFFFFFFF9, borrow=1.
3. a=0x80000000, b=1, is_signed=1.
   - Expect d=0x7FFFFFFF, overflow=1, borrow=0.
   - Same operands with is_signed=0: expect overflow=0.
4. a=b=0x12345678.
   - Expect d=0, zero=1, borrow=0.
   - Also a=0, b=0x7FFFFFFF, is_signed=1: expect d=0x80000001, overflow=0, borrow=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE, and toggle in_valid and a during this time.
   - Expect d and flags stable, in_ready=0, new inputs ignored.
   - Raise out_ready: in_ready=1 next cycle, then the next op computes correctly.
6. Reset mid-RUN: assert rst_n=0 asynchronously after 2 chunks.
   - Expect immediately out_valid=0, in_ready=1, d=0.
   - Release and run a=5, b=5: expect d=0, zero=1, no residue from the aborted op.
